// File: rtl/reclone_tmds_pkg.sv
// Shared TMDS definitions: control symbols, clock-channel pattern, word/half payloads,
// gearbox state encoding and the word-to-half split helper.
package reclone_tmds_pkg;

  localparam int unsigned SYM_W      = 10;
  localparam int unsigned HALF_W     = 5;
  localparam int unsigned WORD_W     = 4 * SYM_W;
  localparam int unsigned FILL_CNT_W = 8;
  localparam int unsigned LOCK_WIN_W = 8;

  // DVI control-period symbols indexed by {C1, C0}
  localparam logic [SYM_W-1:0] TMDS_CTRL_00 = 10'b1101010100;
  localparam logic [SYM_W-1:0] TMDS_CTRL_01 = 10'b0010101011;
  localparam logic [SYM_W-1:0] TMDS_CTRL_10 = 10'b0101010100;
  localparam logic [SYM_W-1:0] TMDS_CTRL_11 = 10'b1010101011;

  localparam logic [SYM_W-1:0] TMDS_CLK_PATTERN = 10'b0000011111;

  typedef struct packed {
    logic [SYM_W-1:0] ch_c;
    logic [SYM_W-1:0] ch2;
    logic [SYM_W-1:0] ch1;
    logic [SYM_W-1:0] ch0;
  } tmds_word_t;

  typedef struct packed {
    logic [HALF_W-1:0] ch_c;
    logic [HALF_W-1:0] ch2;
    logic [HALF_W-1:0] ch1;
    logic [HALF_W-1:0] ch0;
  } tmds_half_t;

  typedef enum logic [1:0] {
    WAIT_FILL = 2'd0,
    STREAM_LO = 2'd1,
    STREAM_HI = 2'd2,
    IDLE_HI   = 2'd3
  } gearbox_state_e;

  // Selects bits [4:0] (upper = 0) or [9:5] (upper = 1) of every channel
  function automatic tmds_half_t half_of(tmds_word_t w, logic upper);
    tmds_half_t h;
    h.ch_c = upper ? w.ch_c[SYM_W-1:HALF_W] : w.ch_c[HALF_W-1:0];
    h.ch2  = upper ? w.ch2[SYM_W-1:HALF_W]  : w.ch2[HALF_W-1:0];
    h.ch1  = upper ? w.ch1[SYM_W-1:HALF_W]  : w.ch1[HALF_W-1:0];
    h.ch0  = upper ? w.ch0[SYM_W-1:HALF_W]  : w.ch0[HALF_W-1:0];
    return h;
  endfunction

  localparam tmds_word_t IDLE_WORD =
    tmds_word_t'({TMDS_CLK_PATTERN, TMDS_CTRL_00, TMDS_CTRL_00, TMDS_CTRL_00});
  localparam tmds_half_t IDLE_HALF_LO = half_of(IDLE_WORD, 1'b0);
  localparam tmds_half_t IDLE_HALF_HI = half_of(IDLE_WORD, 1'b1);

endpackage

// File: rtl/tmds_gearbox_sequencer_if.sv
// FIFO read-side bundle between the pixel-to-load async FIFO (master) and the
// gearbox sequencer (slave); the FIFO is first-word-fall-through.
interface tmds_gearbox_sequencer_if;
  import reclone_tmds_pkg::*;

  logic       fifoEmpty;
  tmds_word_t fifoData;
  logic       fifoReadEnable;

  modport master (output fifoEmpty, output fifoData, input fifoReadEnable);
  modport slave  (input fifoEmpty, input fifoData, output fifoReadEnable);

endinterface

// File: rtl/tmds_saturating_counter.sv
// Saturating up-counter with synchronous clear; clear together with increment loads 1.
module tmds_saturating_counter #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             clr,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = inc ? WIDTH'(1) : '0;
    end else if (inc && (count_q != '1)) begin
      count_d = count_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/tmds_gearbox_sequencer.sv
// Pops one 40-bit TMDS word per two load cycles and emits low then high 5-bit halves per channel.
// Underflow/lock statistics are built only when TMDS_GEARBOX_STATS_EN is defined.
module tmds_gearbox_sequencer
  import reclone_tmds_pkg::*;
#(
  parameter int unsigned FILL_WAIT   = 4,
  parameter int unsigned COUNT_WIDTH = 16
) (
  input  logic                   clock,
  input  logic                   asyncResetN,
  input  logic                   streamEnable,
  tmds_gearbox_sequencer_if.slave fifo,
  output logic [HALF_W-1:0]      lvds0Data,
  output logic [HALF_W-1:0]      lvds1Data,
  output logic [HALF_W-1:0]      lvds2Data,
  output logic [HALF_W-1:0]      lvdsCData,
  output logic                   locked,
  output logic                   underflowPulse,
  output logic [COUNT_WIDTH-1:0] underflowCount,
  input  logic                   clearStats
);

  gearbox_state_e          state_q, state_d;
  logic                    phase_q, phase_d;
  logic [FILL_CNT_W-1:0]   fill_q, fill_d;
  tmds_half_t              hold_q, hold_d;
  tmds_half_t              out_q, out_d;
  logic                    pulse_q, pulse_d;
  logic                    locked_q, locked_d;
  logic                    pop_c;
  logic                    underflow_c;

  // Slot sequencing; WAIT_FILL keeps an idle lo/hi pair cadence so it only exits on a pair boundary
  always_comb begin
    state_d     = state_q;
    phase_d     = 1'b0;
    fill_d      = '0;
    hold_d      = hold_q;
    out_d       = IDLE_HALF_LO;
    pop_c       = 1'b0;
    underflow_c = 1'b0;
    case (state_q)
      WAIT_FILL: begin
        phase_d = ~phase_q;
        out_d   = phase_q ? IDLE_HALF_HI : IDLE_HALF_LO;
        if (!fifo.fifoEmpty) begin
          fill_d = (fill_q == '1) ? fill_q : fill_q + FILL_CNT_W'(1);
        end
        if (phase_q && streamEnable && (fill_q >= FILL_CNT_W'(FILL_WAIT))) begin
          state_d = STREAM_LO;
        end
      end
      STREAM_LO: begin
        state_d = IDLE_HI;
        if (streamEnable && fifo.fifoEmpty) begin
          underflow_c = 1'b1;
        end else if (streamEnable) begin
          pop_c   = 1'b1;
          out_d   = half_of(fifo.fifoData, 1'b0);
          hold_d  = half_of(fifo.fifoData, 1'b1);
          state_d = STREAM_HI;
        end
      end
      STREAM_HI: begin
        out_d   = hold_q;
        state_d = STREAM_LO;
      end
      IDLE_HI: begin
        out_d   = IDLE_HALF_HI;
        state_d = streamEnable ? STREAM_LO : WAIT_FILL;
      end
      default: begin
        state_d = WAIT_FILL;
      end
    endcase
  end

  assign fifo.fifoReadEnable = pop_c;

`ifdef TMDS_GEARBOX_STATS_EN
  logic [LOCK_WIN_W-1:0] lock_win;

  tmds_saturating_counter #(.WIDTH(COUNT_WIDTH)) u_underflow_cnt (
    .clk   (clock),
    .rst_n (asyncResetN),
    .inc   (underflow_c),
    .clr   (clearStats),
    .count (underflowCount)
  );

  // Counts good word slots since the last underflow or fill period
  tmds_saturating_counter #(.WIDTH(LOCK_WIN_W)) u_lock_win (
    .clk   (clock),
    .rst_n (asyncResetN),
    .inc   (pop_c),
    .clr   (underflow_c || (state_q == WAIT_FILL)),
    .count (lock_win)
  );

  always_comb begin
    pulse_d  = underflow_c;
    locked_d = (state_d != WAIT_FILL) && !underflow_c &&
               (locked_q || (pop_c && (lock_win == '1)));
  end
`else
  logic unused_stats;
  assign unused_stats   = clearStats ^ underflow_c;
  assign underflowCount = '0;

  always_comb begin
    pulse_d  = 1'b0;
    locked_d = (state_d != WAIT_FILL);
  end
`endif

  always_ff @(posedge clock or negedge asyncResetN) begin
    if (!asyncResetN) begin
      state_q  <= WAIT_FILL;
      phase_q  <= 1'b0;
      fill_q   <= '0;
      hold_q   <= IDLE_HALF_HI;
      out_q    <= IDLE_HALF_LO;
      pulse_q  <= 1'b0;
      locked_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      phase_q  <= phase_d;
      fill_q   <= fill_d;
      hold_q   <= hold_d;
      out_q    <= out_d;
      pulse_q  <= pulse_d;
      locked_q <= locked_d;
    end
  end

  assign lvds0Data      = out_q.ch0;
  assign lvds1Data      = out_q.ch1;
  assign lvds2Data      = out_q.ch2;
  assign lvdsCData      = out_q.ch_c;
  assign underflowPulse = pulse_q;
  assign locked         = locked_q;

endmodule

// File: tb/tb_tmds_gearbox_sequencer.sv
// Randomized self-checking bench for tmds_gearbox_sequencer against a slot-level reference model;
// follows TMDS_GEARBOX_STATS_EN for the statistics outputs.
module tb_tmds_gearbox_sequencer;

  localparam int unsigned FILL_WAIT   = 4;
  localparam int unsigned COUNT_WIDTH = 10;
`ifdef TMDS_GEARBOX_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif
  localparam int SAT_MAX  = (1 << COUNT_WIDTH) - 1;
  localparam int LOCK_LEN = 256;

  // Idle word halves {chC, ch2, ch1, ch0}: control symbol 1101010100, clock 0000011111
  localparam logic [19:0] T_IDLE_LO = {5'b11111, 5'b10100, 5'b10100, 5'b10100};
  localparam logic [19:0] T_IDLE_HI = {5'b00000, 5'b11010, 5'b11010, 5'b11010};
  localparam logic [39:0] W_ONES    = 40'h00000_003FF;
  localparam logic [39:0] W_PLAN    = {10'h3E0, 10'h155, 10'h2AA, 10'h001};

  logic                   clock = 1'b0;
  logic                   asyncResetN;
  logic                   streamEnable;
  logic                   clearStats;
  logic [4:0]             lvds0Data, lvds1Data, lvds2Data, lvdsCData;
  logic                   locked;
  logic                   underflowPulse;
  logic [COUNT_WIDTH-1:0] underflowCount;

  int n_tests;
  int n_failed;

  tmds_gearbox_sequencer_if fifo_if ();

  tmds_gearbox_sequencer #(
    .FILL_WAIT   (FILL_WAIT),
    .COUNT_WIDTH (COUNT_WIDTH)
  ) dut (
    .clock          (clock),
    .asyncResetN    (asyncResetN),
    .streamEnable   (streamEnable),
    .fifo           (fifo_if),
    .lvds0Data      (lvds0Data),
    .lvds1Data      (lvds1Data),
    .lvds2Data      (lvds2Data),
    .lvdsCData      (lvdsCData),
    .locked         (locked),
    .underflowPulse (underflowPulse),
    .underflowCount (underflowCount),
    .clearStats     (clearStats)
  );

  always #5 clock = ~clock;

  // Reference model: a word slot is two output cycles; the model tracks whether it is
  // streaming, which half of the slot comes next and what the high half will be.
  bit          m_stream;
  bit          m_second;
  bit          m_word;
  int          m_fill;
  int          m_run;
  int          m_ucnt;
  logic [19:0] m_pend;
  logic [19:0] exp_out;
  bit          exp_pop;
  bit          exp_pulse;
  bit          exp_locked;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [19:0] lo20(input logic [39:0] w);
    return {w[34:30], w[24:20], w[14:10], w[4:0]};
  endfunction

  function automatic logic [19:0] hi20(input logic [39:0] w);
    return {w[39:35], w[29:25], w[19:15], w[9:5]};
  endfunction

  task automatic model_reset();
    m_stream = 1'b0;
    m_second = 1'b0;
    m_word   = 1'b0;
    m_fill   = 0;
    m_run    = 0;
    m_ucnt   = 0;
    m_pend   = T_IDLE_HI;
  endtask

  task automatic model_step(input bit en, input bit empty, input logic [39:0] d, input bit clr);
    bit was_stream;
    bit uf;
    was_stream = m_stream;
    uf         = 1'b0;
    exp_pop    = 1'b0;
    if (!m_second) begin
      if (m_stream && en && !empty) begin
        exp_pop = 1'b1;
        exp_out = lo20(d);
        m_pend  = hi20(d);
        m_word  = 1'b1;
        m_run++;
      end else begin
        exp_out = T_IDLE_LO;
        m_pend  = T_IDLE_HI;
        m_word  = 1'b0;
        uf      = m_stream && en;
      end
      m_second = 1'b1;
    end else begin
      exp_out  = m_pend;
      m_second = 1'b0;
      if (m_stream) begin
        if (!m_word && !en) begin
          m_stream = 1'b0;
          m_run    = 0;
        end
      end else if (en && (m_fill >= int'(FILL_WAIT))) begin
        m_stream = 1'b1;
      end
    end
    m_fill = (!was_stream && !empty) ? ((m_fill < 255) ? m_fill + 1 : 255) : 0;
    if (uf) m_run = 0;
    if (STATS) begin
      if (uf) m_ucnt = clr ? 1 : ((m_ucnt < SAT_MAX) ? m_ucnt + 1 : m_ucnt);
      else if (clr) m_ucnt = 0;
      exp_pulse  = uf;
      exp_locked = m_stream && (m_run >= LOCK_LEN);
    end else begin
      m_ucnt     = 0;
      exp_pulse  = 1'b0;
      exp_locked = m_stream;
    end
  endtask

  task automatic run_cycle(input bit en, input bit empty, input logic [39:0] d, input bit clr);
    @(negedge clock);
    streamEnable      = en;
    fifo_if.fifoEmpty = empty;
    fifo_if.fifoData  = d;
    clearStats        = clr;
    #1;
    model_step(en, empty, d, clr);
    check_eq("pop", 64'(fifo_if.fifoReadEnable), 64'(exp_pop));
    @(posedge clock);
    #1;
    check_eq("lvds", 64'({lvdsCData, lvds2Data, lvds1Data, lvds0Data}), 64'(exp_out));
    check_eq("pulse", 64'(underflowPulse), 64'(exp_pulse));
    check_eq("locked", 64'(locked), 64'(exp_locked));
    check_eq("count", 64'(underflowCount), 64'(m_ucnt));
  endtask

  task automatic check_reset_values(input string tag);
    check_eq({tag, "_lvds0"}, 64'(lvds0Data), 64'(5'b10100));
    check_eq({tag, "_lvds1"}, 64'(lvds1Data), 64'(5'b10100));
    check_eq({tag, "_lvds2"}, 64'(lvds2Data), 64'(5'b10100));
    check_eq({tag, "_lvdsC"}, 64'(lvdsCData), 64'(5'b11111));
    check_eq({tag, "_pop"}, 64'(fifo_if.fifoReadEnable), 64'(0));
    check_eq({tag, "_locked"}, 64'(locked), 64'(0));
    check_eq({tag, "_pulse"}, 64'(underflowPulse), 64'(0));
    check_eq({tag, "_count"}, 64'(underflowCount), 64'(0));
  endtask

  // Streams non-empty words until the model reaches the requested slot position
  task automatic sync_to(input string tag, input bit want_second, input logic [39:0] d);
    int k;
    k = 0;
    while (k < 40 && !(m_stream && (m_second == want_second) && (!want_second || m_word))) begin
      run_cycle(1'b1, 1'b0, d, 1'b0);
      k++;
    end
    check_eq(tag, 64'(m_stream && (m_second == want_second)), 64'(1));
  endtask

  initial begin
    logic [63:0] r;
    n_tests              = 0;
    n_failed             = 0;
    asyncResetN          = 1'b0;
    streamEnable         = 1'b0;
    clearStats           = 1'b0;
    fifo_if.fifoEmpty    = 1'b1;
    fifo_if.fifoData     = '0;
    model_reset();
    repeat (2) @(posedge clock);
    #1;
    check_reset_values("por");
    asyncResetN = 1'b1;

    // Constant 0x003FF words: idle pairs during fill, then ch0 all ones, ch1 zero
    for (int i = 0; i < 40; i++) run_cycle(1'b1, 1'b0, W_ONES, 1'b0);
    check_eq("ones_ch0", 64'(lvds0Data), 64'(5'h1F));
    check_eq("ones_ch1", 64'(lvds1Data), 64'(5'h00));

    // Directed word: ch0 0x001 and chC 0x3E0 split lo then hi
    sync_to("sync_plan", 1'b0, W_PLAN);
    run_cycle(1'b1, 1'b0, W_PLAN, 1'b0);
    check_eq("plan_lo_ch0", 64'(lvds0Data), 64'(5'h01));
    check_eq("plan_lo_chC", 64'(lvdsCData), 64'(5'h00));
    run_cycle(1'b1, 1'b1, W_PLAN, 1'b0);
    check_eq("plan_hi_ch0", 64'(lvds0Data), 64'(5'h00));
    check_eq("plan_hi_chC", 64'(lvdsCData), 64'(5'h1F));

    // Long clean run to reach lock
    for (int i = 0; i < 2 * LOCK_LEN + 20; i++) begin
      r = {$urandom(), $urandom()};
      run_cycle(1'b1, 1'b0, r[39:0], 1'b0);
    end
    check_eq("lock_set", 64'(locked), 64'(1));

    // Single underflow slot
    sync_to("sync_uf", 1'b0, W_ONES);
    run_cycle(1'b1, 1'b1, W_ONES, 1'b0);
    check_eq("uf_pulse", 64'(underflowPulse), 64'(STATS));
    check_eq("uf_locked", 64'(locked), 64'(!STATS));
    for (int i = 0; i < 6; i++) run_cycle(1'b1, 1'b0, W_ONES, 1'b0);

    // streamEnable drops in the high half of a word slot
    sync_to("sync_drop", 1'b1, W_PLAN);
    for (int i = 0; i < 8; i++) run_cycle(1'b0, 1'b0, W_PLAN, 1'b0);
    check_eq("drop_locked", 64'(locked), 64'(0));

    // Reset mid-word, then refill before the next pop
    for (int i = 0; i < 12; i++) run_cycle(1'b1, 1'b0, W_PLAN, 1'b0);
    sync_to("sync_rst", 1'b1, W_PLAN);
    @(negedge clock);
    asyncResetN = 1'b0;
    #1;
    check_reset_values("midrst");
    model_reset();
    @(posedge clock);
    #1;
    asyncResetN = 1'b1;
    for (int i = 0; i < 16; i++) run_cycle(1'b1, 1'b0, W_ONES, 1'b0);

    // Underflow counter saturation and clear racing an underflow
    for (int i = 0; i < 2 * (SAT_MAX + 20); i++) run_cycle(1'b1, 1'b1, 40'h0, 1'b0);
    check_eq("sat", 64'(underflowCount), 64'(STATS ? SAT_MAX : 0));
    if (m_second) run_cycle(1'b1, 1'b1, 40'h0, 1'b0);
    run_cycle(1'b1, 1'b1, 40'h0, 1'b1);
    check_eq("clr_uf", 64'(underflowCount), 64'(STATS ? 1 : 0));
    run_cycle(1'b1, 1'b1, 40'h0, 1'b1);
    check_eq("clr_only", 64'(underflowCount), 64'(0));

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      r = {$urandom(), $urandom()};
      run_cycle($urandom_range(0, 15) != 0, $urandom_range(0, 4) == 0, r[39:0],
                $urandom_range(0, 63) == 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_failed);
    $finish;
  end

endmodule
